// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Sequential 16x16 unsigned multiply / 16/16 unsigned divide unit.
//             Operands come from two register-file read ports. The 32-bit
//             result goes back to the register file as two consecutive
//             writes: the low word to dest_addr, then the high word to
//             dest_addr+1.
//             Multiply : radix-2 shift-add.
//                        lo = product[15:0], hi = product[31:16].
//             Divide   : restoring shift-subtract.
//                        lo = quotient, hi = remainder.
//             Div by 0 : skips the iteration phase.
//                        lo = 16'hFFFF, hi = dividend, dbz set.
//  Ports    : clk        rising-edge clock
//             rst_n      asynchronous active-low reset
//             start      request strobe, sampled only while idle
//             op         0 = multiply, 1 = divide
//             r_bus      operand A (multiplicand / dividend)
//             s_bus      operand B (multiplier / divisor)
//             dest_addr  destination register for the low word
//             busy       operation in flight
//             d_write    register-file write strobe
//             d_addr     register-file write address
//             d_bus      register-file write data
//             done       one-cycle pulse on the final (high-word) write
//             dbz        sticky divide-by-zero flag, cleared by next start
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        op,
   input  logic [15:0] r_bus,
   input  logic [15:0] s_bus,
   input  logic [3:0]  dest_addr,
   output logic        busy,
   output logic        d_write,
   output logic [3:0]  d_addr,
   output logic [15:0] d_bus,
   output logic        done,
   output logic        dbz
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_WR_LO = 2'd2,
      ST_WR_HI = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic        r_op;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [3:0]  r_dest;
   logic [4:0]  r_cnt;
   logic [15:0] r_hi;     // product high half / partial remainder
   logic [15:0] r_lo;     // multiplier being shifted out / quotient shifted in
   logic        r_dbz;

   logic        w_accept;
   logic        w_dz;
   logic        w_last;
   logic [16:0] w_madd;
   logic [16:0] w_prem;
   logic [16:0] w_diff;
   logic        w_fits;

   assign w_accept = (r_state == ST_IDLE) && start;
   assign w_dz     = op && (s_bus == 16'd0);
   assign w_last   = (r_cnt == 5'd15);

   // Multiply step: conditional add into the high half. The 17th bit is the
   // carry, which is shifted down into the high half on the same edge.
   assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 17'd0);

   // Divide step: 17-bit partial remainder formed by shifting in the next
   // dividend bit. A non-negative trial difference means the divisor fits.
   assign w_prem   = {r_hi, r_lo[15]};
   assign w_diff   = w_prem - {1'b0, r_b};
   assign w_fits   = ~w_diff[16];

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state and state-decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_next  = r_state;
      busy    = 1'b0;
      d_write = 1'b0;
      d_addr  = 4'd0;
      d_bus   = 16'd0;
      done    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = w_dz ? ST_WR_LO : ST_CALC;
            end
         end
         ST_CALC: begin
            busy = 1'b1;
            if (w_last) begin
               w_next = ST_WR_LO;
            end
         end
         ST_WR_LO: begin
            busy    = 1'b1;
            d_write = 1'b1;
            d_addr  = r_dest;
            d_bus   = r_lo;
            w_next  = ST_WR_HI;
         end
         ST_WR_HI: begin
            busy    = 1'b1;
            d_write = 1'b1;
            d_addr  = r_dest + 4'd1;   // wraps 15 -> 0
            d_bus   = r_hi;
            done    = 1'b1;
            w_next  = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Operand latches, iteration counter and datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op   <= 1'b0;
         r_a    <= 16'd0;
         r_b    <= 16'd0;
         r_dest <= 4'd0;
         r_cnt  <= 5'd0;
         r_hi   <= 16'd0;
         r_lo   <= 16'd0;
         r_dbz  <= 1'b0;
      end else if (w_accept) begin
         r_op   <= op;
         r_a    <= r_bus;
         r_b    <= s_bus;
         r_dest <= dest_addr;
         r_cnt  <= 5'd0;
         r_dbz  <= w_dz;
         if (w_dz) begin
            // Result is final already; the write states just emit it.
            r_hi <= r_bus;
            r_lo <= 16'hFFFF;
         end else begin
            r_hi <= 16'd0;
            r_lo <= op ? r_bus : s_bus;
         end
      end else if (r_state == ST_CALC) begin
         r_cnt <= r_cnt + 5'd1;
         if (!r_op) begin
            {r_hi, r_lo} <= {w_madd, r_lo[15:1]};
         end else begin
            // The remainder is always below the divisor, so 16 bits hold it.
            r_hi <= w_fits ? w_diff[15:0] : w_prem[15:0];
            r_lo <= {r_lo[14:0], w_fits};
         end
      end
   end

   assign dbz = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit. A timeline model predicts
//             the outputs of every cycle from plain arithmetic. Directed
//             operations with literal expectations pin the model, and a long
//             random phase exercises back-to-back and ignored starts.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        op;
   logic [15:0] r_bus;
   logic [15:0] s_bus;
   logic [3:0]  dest_addr;
   logic        busy;
   logic        d_write;
   logic [3:0]  d_addr;
   logic [15:0] d_bus;
   logic        done;
   logic        dbz;

   int n_chk  = 0;
   int n_fail = 0;

   muldiv_unit u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .r_bus     (r_bus),
      .s_bus     (s_bus),
      .dest_addr (dest_addr),
      .busy      (busy),
      .d_write   (d_write),
      .d_addr    (d_addr),
      .d_bus     (d_bus),
      .done      (done),
      .dbz       (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: a queue holding the expected outputs of every
   // future cycle of the operation in flight.
   // ------------------------------------------------------------------
   typedef struct packed {
      logic        busy;
      logic        wr;
      logic        done;
      logic [3:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   logic        m_dbz;
   logic        m_dz;
   logic [31:0] m_prod;
   logic [15:0] m_lo;
   logic [15:0] m_hi;
   logic [3:0]  m_a1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         cur   = '0;
         m_dbz = 1'b0;
      end else begin
         if (!cur.busy && start) begin
            m_dz = op && (s_bus == 16'd0);
            if (!op) begin
               m_prod = 32'(r_bus) * 32'(s_bus);
               m_lo   = m_prod[15:0];
               m_hi   = m_prod[31:16];
            end else if (m_dz) begin
               m_lo = 16'hFFFF;
               m_hi = r_bus;
            end else begin
               m_lo = r_bus / s_bus;
               m_hi = r_bus % s_bus;
            end
            m_dbz = m_dz;
            m_a1  = dest_addr + 4'd1;
            if (!m_dz) begin
               for (int k = 0; k < 16; k++) q.push_back({1'b1, 1'b0, 1'b0, 4'd0, 16'd0});
            end
            q.push_back({1'b1, 1'b1, 1'b0, dest_addr, m_lo});
            q.push_back({1'b1, 1'b1, 1'b1, m_a1, m_hi});
         end
         cur = (q.size() > 0) ? q.pop_front() : '0;
      end
   end

   // One comparison of all outputs per cycle.
   always @(negedge clk) begin
      chk("cycle_outputs",
          {8'd0, busy, d_write, done, dbz, d_addr, d_bus},
          {8'd0, cur.busy, cur.wr, cur.done, m_dbz, cur.addr, cur.data});
   end

   // ------------------------------------------------------------------
   // Directed operation with capture of both writes.
   // i counts cycles after the accepting edge E0.
   // ------------------------------------------------------------------
   task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] dst, input int inj,
                         output int first_wr, output int idle_at,
                         output logic [3:0] lo_a, output logic [15:0] lo_d,
                         output logic [3:0] hi_a, output logic [15:0] hi_d,
                         output logic hi_done);
      int nwr;
      nwr      = 0;
      first_wr = -1;
      idle_at  = -1;
      lo_a = 4'd0; lo_d = 16'd0; hi_a = 4'd0; hi_d = 16'd0; hi_done = 1'b0;
      @(negedge clk);
      start = 1'b1; op = o; r_bus = a; s_bus = b; dest_addr = dst;
      @(negedge clk);
      start = 1'b0;
      r_bus = 16'($urandom); s_bus = 16'($urandom); dest_addr = 4'($urandom);
      for (int i = 1; i <= 40; i++) begin
         if (d_write) begin
            if (nwr == 0) begin
               first_wr = i; lo_a = d_addr; lo_d = d_bus;
            end else begin
               hi_a = d_addr; hi_d = d_bus; hi_done = done;
            end
            nwr++;
         end
         if (!busy) begin
            idle_at = i;
            break;
         end
         if (i == inj) begin
            start = 1'b1; op = ~o;
            r_bus = 16'($urandom); s_bus = 16'($urandom) | 16'd1; dest_addr = 4'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("op_completed_in_budget", 32'(idle_at > 0), 32'd1);
   endtask

   int          fw, ia;
   logic [3:0]  la, ha;
   logic [15:0] ld, hd;
   logic        hdn;

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 1'b0;
      r_bus = 16'd0; s_bus = 16'd0; dest_addr = 4'd0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {26'd0, busy, d_write, done, dbz, d_addr == 4'd0, d_bus == 16'd0},
          {26'd0, 6'b000011});
      rst_n = 1'b1;

      // 3 x 5 -> dest 2
      run_op(1'b0, 16'd3, 16'd5, 4'd2, 0, fw, ia, la, ld, ha, hd, hdn);
      chk("mul3x5_first_write_cycle", 32'(fw), 32'd17);
      chk("mul3x5_lo", {la, ld}, {4'd2, 16'h000F});
      chk("mul3x5_hi", {hdn, ha, hd}, {1'b1, 4'd3, 16'h0000});
      chk("mul3x5_idle_cycle", 32'(ia), 32'd19);

      // 0xFFFF x 0xFFFF -> dest 15, high address wraps to 0
      run_op(1'b0, 16'hFFFF, 16'hFFFF, 4'd15, 0, fw, ia, la, ld, ha, hd, hdn);
      chk("mulmax_lo", {la, ld}, {4'd15, 16'h0001});
      chk("mulmax_hi_wrap", {ha, hd}, {4'd0, 16'hFFFE});

      // 1234 / 0 -> dest 6
      run_op(1'b1, 16'd1234, 16'd0, 4'd6, 0, fw, ia, la, ld, ha, hd, hdn);
      chk("dbz_first_write_cycle", 32'(fw), 32'd1);
      chk("dbz_lo", {la, ld}, {4'd6, 16'hFFFF});
      chk("dbz_hi", {hdn, ha, hd}, {1'b1, 4'd7, 16'h04D2});
      chk("dbz_idle_cycle", 32'(ia), 32'd3);
      repeat (3) @(negedge clk);
      chk("dbz_sticky", 32'(dbz), 32'd1);

      // 100 / 7 -> dest 4, clears dbz
      run_op(1'b1, 16'd100, 16'd7, 4'd4, 0, fw, ia, la, ld, ha, hd, hdn);
      chk("div_lo", {la, ld}, {4'd4, 16'h000E});
      chk("div_hi", {ha, hd}, {4'd5, 16'h0002});
      chk("div_dbz_cleared", 32'(dbz), 32'd0);

      // start pulsed during iteration 5 is ignored
      run_op(1'b0, 16'd300, 16'd21, 4'd9, 5, fw, ia, la, ld, ha, hd, hdn);
      chk("ignored_start_lo", {la, ld}, {4'd9, 16'd6300});
      chk("ignored_start_hi", {ha, hd}, {4'd10, 16'd0});
      chk("ignored_start_timing", 32'(fw), 32'd17);
      chk("ignored_start_idle", 32'(ia), 32'd19);

      // reset during iteration 8 aborts the operation
      @(negedge clk);
      start = 1'b1; op = 1'b0; r_bus = 16'd1000; s_bus = 16'd1000; dest_addr = 4'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("abort_immediate", {29'd0, busy, d_write, done}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_write", 32'(d_write), 32'd0);
      end
      rst_n = 1'b1;
      run_op(1'b0, 16'd2, 16'd2, 4'd0, 0, fw, ia, la, ld, ha, hd, hdn);
      chk("post_reset_lo", {la, ld}, {4'd0, 16'h0004});
      chk("post_reset_hi", {ha, hd}, {4'd1, 16'h0000});
      chk("post_reset_timing", 32'(fw), 32'd17);

      // Randomized phase: all cycles checked by the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         start     = ($urandom % 4) == 0;
         op        = 1'($urandom);
         r_bus     = (($urandom % 8) == 0) ? 16'hFFFF : 16'($urandom);
         case ($urandom % 8)
            0:       s_bus = 16'd0;
            1:       s_bus = 16'hFFFF;
            2:       s_bus = 16'($urandom % 16);
            default: s_bus = 16'($urandom);
         endcase
         dest_addr = 4'($urandom);
      end
      start = 1'b0;
      repeat (25) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
